// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: byte/half/word accesses on a variable-latency word bus
// Optional alignment trap: define MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_off, r_size;
  logic        r_sext, r_we, r_err, r_mis;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]  r_bus_be;

  logic        w_bad, w_no_op, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef MAU_ALIGN_CHECK_EN
  assign w_bad = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
`else
  assign w_bad = 1'b0;
`endif

  // A request with neither direction set completes at once as a null access.
  assign w_no_op   = ~(mem_read | mem_write);
  assign w_timeout = (r_cnt == LP_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = bus_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      2'b00:   w_ld = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ld = bus_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = (w_bad | w_no_op) ? S_DONE : S_REQ;
      S_REQ:  if (bus_ack | w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_sext      <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_mis       <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_off       <= addr[1:0];
          r_size      <= size;
          r_sext      <= sign_ext;
          r_we        <= mem_write;
          r_bus_addr  <= {addr[31:2], 2'b00};
          r_bus_be    <= w_be;
          r_bus_wdata <= w_wdata;
          r_cnt       <= '0;
          r_rdata     <= '0;
          r_err       <= 1'b0;
          r_mis       <= w_bad & ~w_no_op;
        end
        S_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus_ack)        r_rdata <= r_we ? 32'd0 : w_ld;
          else if (w_timeout) r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) & req_valid) | (r_state == S_REQ);
  assign done      = (r_state == S_DONE);
  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = bus_req & r_we;
  assign rdata     = done ? r_rdata : 32'd0;
  assign misalign  = done & r_mis;
  assign bus_err   = done & r_err;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 6;
`ifdef MAU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req_valid, mem_read, mem_write, sign_ext, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [31:0] a, input logic [1:0] sz);
    int o;
    o = int'(a % 4);
    return o - (o % nbytes(sz));
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= lane_off(a, sz) && i < lane_off(a, sz) + nbytes(sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] brd, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sx);
    logic [31:0] v;
    int n, off;
    n = nbytes(sz);
    off = lane_off(a, sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = brd[8*(off + i) +: 8];
    if (sx && n < 4 && v[8*n - 1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // waits = wait cycles before ack; waits >= TO means the bus never answers.
  task automatic run_access(input bit we, input logic [1:0] sz, input bit sx,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] brd, input int waits);
    bit fault, exp_err, fin;
    int exp_req, nreq, nstall, cyc;
    logic [31:0] exp_rd;
    fault   = ALIGN_CHK && ((a % nbytes(sz)) != 0);
    exp_err = !fault && (waits >= TO);
    exp_req = fault ? 0 : ((waits < TO) ? waits + 1 : TO);
    exp_rd  = (fault || we || exp_err) ? 32'd0 : model_load(brd, a, sz, sx);
    nreq = 0; nstall = 0; cyc = 0; fin = 1'b0;
    req_valid = 1'b1; mem_write = we; mem_read = ~we;
    size = sz; sign_ext = sx; addr = a; wdata = wd;
    while (!fin && cyc < TO + 10) begin
      #1;
      if (done) fin = 1'b1;
      else begin
        if (stall) nstall++;
        if (bus_req) begin
          nreq++;
          if (nreq == 1) begin
            check_eq("bus_addr", bus_addr, {a[31:2], 2'b00});
            check_eq("bus_be", {28'd0, bus_be}, {28'd0, model_be(a, sz)});
            check_eq("bus_wdata", bus_wdata, model_wdata(wd, sz));
            check_eq("bus_we", {31'd0, bus_we}, {31'd0, we});
          end
          if (nreq - 1 == waits) begin
            bus_ack = 1'b1;
            bus_rdata = brd;
          end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        cyc++;
      end
    end
    check_eq("done_seen", {31'd0, fin}, 32'd1);
    check_eq("rdata", rdata, exp_rd);
    check_eq("misalign", {31'd0, misalign}, {31'd0, fault});
    check_eq("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    check_eq("stall_in_done", {31'd0, stall}, 32'd0);
    check_eq("req_cycles", nreq, exp_req);
    check_eq("stall_cycles", nstall, exp_req + 1);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (exp_err) begin
      bus_ack = 1'b1;
      bus_rdata = brd;
    end
    @(negedge clk);
    #1;
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_req", {31'd0, bus_req}, 32'd0);
    check_eq("idle_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0);
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 2);
    run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 5);
    run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h12345678, 1);
    run_access(1'b0, 2'b01, 1'b1, 32'h301, 32'h0, 32'hC0018765, 0);
    run_access(1'b0, 2'b11, 1'b1, 32'h404, 32'h0, 32'h89ABCDEF, 3);
    run_access(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'hFFFFFFFF, TO);

    for (int k = 0; k < 60; k++)
      run_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, TO + 1)));

    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    size = 2'b10; sign_ext = 1'b0; addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_bus_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_rst_req", {31'd0, bus_req}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_access(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h00007F00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store stage directly downstream of the ALU in the single-cycle core. It takes the ALU result as the effective address and performs byte/half/word loads and stores against a word-wide, variable-latency data bus. While an access is in flight it stalls the core. It returns sign- or zero-extended load data to write-back.

## Interface
- TIMEOUT, 255: cycles to wait for `bus_ack` before aborting the access (1..65535).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  the current instruction is a memory op (MemRead or MemWrite).
- mem_read  in  1  load.
- mem_write  in  1  store; has priority over `mem_read` when both are high.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- addr  in  32  effective address (ALU `ans`).
- wdata  in  32  store data (rt).
- stall  out  1  hold PC and pipeline registers.
- done  out  1  one-cycle pulse: access complete, `rdata` valid.
- rdata  out  32  extended load data; 0 for stores and aborted accesses.
- misalign  out  1  pulses with `done` on an alignment fault.
- bus_err  out  1  pulses with `done` on a timeout.
- bus_req  out  1  request, held until ack or timeout.
- bus_we  out  1  1 for a write.
- bus_addr  out  32  `{addr[31:2],2'b00}`, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_ack  in  1  single-cycle acknowledge; `bus_rdata` is valid in the same cycle.
- bus_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with `req_valid`=0: no action.
- IDLE with `req_valid`=1 and a legal access:
  - capture `addr[1:0]`, size, sign_ext and direction;
  - drive `bus_addr`, `bus_be` and `bus_wdata`;
  - go to REQ.
- REQ: hold `bus_req`=1 and all bus outputs stable.
  - On `bus_ack`: latch the extracted read data and go to DONE.
  - On reaching TIMEOUT cycles without ack: go to DONE with `bus_err`=1.
- DONE: `done`=1 for one cycle, then return to IDLE. `req_valid` is ignored in DONE because it still belongs to the finishing instruction.
- Byte enables (little-endian):
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << {addr[1],1'b0}`;
  - word: `4'b1111`.
- Store data lanes: byte replicated as `{4{wdata[7:0]}}`; half as `{2{wdata[15:0]}}`; word as is.
- Load data: select the byte or half lane given by the captured `addr[1:0]`, then extend per `sign_ext`.
- Alignment faults: half with `addr[0]`=1; word with `addr[1:0]`≠0. Handling depends on the configuration macro below.
- Timeout counter: 16-bit, cleared on entry to REQ. `bus_err` leaves `rdata`=0 and skips write-back. A late ack after abort is ignored.

## Timing
- `stall` = (IDLE & `req_valid`) | REQ, combinational. It is 0 in DONE, so the core advances on the DONE cycle.
- Minimum latency (ack in the first REQ cycle): 3 cycles from IDLE to the end of DONE; `stall` high for 2 of them.
- Every additional wait cycle adds one stall cycle.
- Reset values: state IDLE; counter 0; all outputs 0, except `stall`, which follows its combinational equation and is 0 once the FSM is in IDLE with `req_valid` low.
- Reset asserted mid-access: at that edge, enter IDLE and drop `bus_req`. The outstanding bus transaction is abandoned.
- `bus_ack` outside REQ: ignored.

## Configuration
- `MAU_ALIGN_CHECK_EN` defined:
  - a misaligned request in IDLE goes straight to DONE with `misalign`=1 and `rdata`=0;
  - no bus request is issued;
  - `stall` is high for that one IDLE cycle.
- Not defined:
  - `misalign` is tied 0;
  - offending low address bits are ignored: half uses the lane at `{addr[1],0}`, word uses lane 0;
  - the access proceeds normally.

## Test plan
- Word store, `addr`=0x100, `wdata`=0xDEADBEEF, ack on the 1st REQ cycle -> `bus_addr`=0x100, `bus_be`=1111, `bus_we`=1, `done` 2 cycles after request, `stall` high 2 cycles.
- Byte load, `addr`=0x103, `bus_rdata`=0x80FF1234, `sign_ext`=1 -> `rdata`=0xFFFFFF80; with `sign_ext`=0 -> 0x00000080. `bus_be`=1000.
- Half store, `addr`=0x202, `wdata`=0x0000ABCD, ack after 5 wait cycles -> `bus_be`=1100, `bus_wdata`=0xABCDABCD, `stall` high 7 cycles.
- Word load at 0x102:
  - with `MAU_ALIGN_CHECK_EN` -> no `bus_req`, `misalign`=1, `rdata`=0;
  - without the macro -> `bus_addr`=0x100 and a normal access.
- TIMEOUT=4 and no ack -> `bus_req` high 4 cycles, then `done`=1, `bus_err`=1, `rdata`=0; a later ack is ignored.
- `rst_n` low during REQ -> next cycle `bus_req`=0, `stall`=0 with `req_valid`=0, state IDLE.
